// File: rtl/order_matcher.sv
// Two-sided order book front end: buffers buy/sell orders in small FIFOs and
// matches the heads price-first, emitting registered trade/cancel pulses.
module order_matcher #(
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_buy_valid,
    output logic                       o_buy_ready,
    input  logic [PRICE_W-1:0]         i_buy_price,
    input  logic [QTY_W-1:0]           i_buy_qty,
    input  logic                       i_sell_valid,
    output logic                       o_sell_ready,
    input  logic [PRICE_W-1:0]         i_sell_price,
    input  logic [QTY_W-1:0]           i_sell_qty,
    input  logic                       i_halt,
    output logic                       o_match_signal,
    output logic [PRICE_W-1:0]         o_match_price,
    output logic [QTY_W-1:0]           o_match_qty,
    output logic                       o_cancel_signal,
    output logic [$clog2(DEPTH):0]     o_buy_count,
    output logic [$clog2(DEPTH):0]     o_sell_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {StIdle, StCheck} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [PRICE_W-1:0] r_buy_price  [DEPTH];
    logic [QTY_W-1:0]   r_buy_qty    [DEPTH];
    logic [PRICE_W-1:0] r_sell_price [DEPTH];
    logic [QTY_W-1:0]   r_sell_qty   [DEPTH];
    logic [AW-1:0]      r_buy_wptr, r_buy_rptr, r_sell_wptr, r_sell_rptr;
    logic [CW-1:0]      r_buy_count, r_sell_count;

    logic               r_match, r_cancel;
    logic [PRICE_W-1:0] r_match_price;
    logic [QTY_W-1:0]   r_match_qty;

    logic               w_buy_push, w_sell_push, w_buy_pop, w_sell_pop;
    logic               w_buy_nonempty, w_sell_nonempty, w_crossed;
    logic               w_do_match, w_do_cancel;
    logic [PRICE_W-1:0] w_buy_head_price, w_sell_head_price;
    logic [QTY_W-1:0]   w_buy_head_qty, w_sell_head_qty;
    logic [QTY_W-1:0]   w_trade_qty, w_buy_rem, w_sell_rem;

    assign o_buy_ready     = (r_buy_count != CW'(DEPTH));
    assign o_sell_ready    = (r_sell_count != CW'(DEPTH));
    // Zero-quantity orders complete the handshake but never occupy an entry.
    assign w_buy_push      = i_buy_valid && o_buy_ready && (i_buy_qty != '0);
    assign w_sell_push     = i_sell_valid && o_sell_ready && (i_sell_qty != '0);
    assign w_buy_nonempty  = (r_buy_count != '0);
    assign w_sell_nonempty = (r_sell_count != '0);

    assign w_buy_head_price  = r_buy_price[r_buy_rptr];
    assign w_buy_head_qty    = r_buy_qty[r_buy_rptr];
    assign w_sell_head_price = r_sell_price[r_sell_rptr];
    assign w_sell_head_qty   = r_sell_qty[r_sell_rptr];
    assign w_crossed         = (w_buy_head_price >= w_sell_head_price);
    assign w_trade_qty       = (w_buy_head_qty < w_sell_head_qty) ? w_buy_head_qty
                                                                  : w_sell_head_qty;
    assign w_buy_rem         = w_buy_head_qty - w_trade_qty;
    assign w_sell_rem        = w_sell_head_qty - w_trade_qty;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_buy_nonempty && w_sell_nonempty && !i_halt) w_state_next = StCheck;
            StCheck: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_do_match  = 1'b0;
        w_do_cancel = 1'b0;
        if (r_state == StCheck && !i_halt && w_buy_nonempty && w_sell_nonempty) begin
            w_do_match  = w_crossed;
            w_do_cancel = !w_crossed;
        end
        w_buy_pop  = w_do_cancel || (w_do_match && (w_buy_rem == '0));
        w_sell_pop = w_do_match && (w_sell_rem == '0);
    end

    // Entry storage needs no reset; validity is tracked by pointers and counts.
    always_ff @(posedge i_clk) begin
        if (w_buy_push) begin
            r_buy_price[r_buy_wptr] <= i_buy_price;
            r_buy_qty[r_buy_wptr]   <= i_buy_qty;
        end
        if (w_do_match && !w_buy_pop) r_buy_qty[r_buy_rptr] <= w_buy_rem;
        if (w_sell_push) begin
            r_sell_price[r_sell_wptr] <= i_sell_price;
            r_sell_qty[r_sell_wptr]   <= i_sell_qty;
        end
        if (w_do_match && !w_sell_pop) r_sell_qty[r_sell_rptr] <= w_sell_rem;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buy_wptr   <= '0;
            r_buy_rptr   <= '0;
            r_buy_count  <= '0;
            r_sell_wptr  <= '0;
            r_sell_rptr  <= '0;
            r_sell_count <= '0;
        end else begin
            if (w_buy_push)  r_buy_wptr  <= r_buy_wptr + 1'b1;
            if (w_buy_pop)   r_buy_rptr  <= r_buy_rptr + 1'b1;
            if (w_sell_push) r_sell_wptr <= r_sell_wptr + 1'b1;
            if (w_sell_pop)  r_sell_rptr <= r_sell_rptr + 1'b1;
            r_buy_count  <= r_buy_count + CW'(w_buy_push) - CW'(w_buy_pop);
            r_sell_count <= r_sell_count + CW'(w_sell_push) - CW'(w_sell_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_match       <= 1'b0;
            r_cancel      <= 1'b0;
            r_match_price <= '0;
            r_match_qty   <= '0;
        end else begin
            r_match  <= w_do_match;
            r_cancel <= w_do_cancel;
            if (w_do_match) begin
                r_match_price <= w_sell_head_price;
                r_match_qty   <= w_trade_qty;
            end
        end
    end

    assign o_match_signal  = r_match;
    assign o_cancel_signal = r_cancel;
    assign o_match_price   = r_match_price;
    assign o_match_qty     = r_match_qty;
    assign o_buy_count     = r_buy_count;
    assign o_sell_count    = r_sell_count;

endmodule

// File: tb/tb_order_matcher.sv
// Directed bench for order_matcher: a per-cycle vector table for the basic
// trade/cancel flows plus hand sequences for reset, halt and FIFO overflow.
module tb_order_matcher;
    logic       clk = 1'b0;
    logic       reset;
    logic       buy_valid, sell_valid, halt;
    logic [7:0] buy_price, buy_qty, sell_price, sell_qty;
    logic       buy_ready, sell_ready, match_signal, cancel_signal;
    logic [7:0] match_price, match_qty;
    logic [2:0] buy_count, sell_count;

    order_matcher #(.PRICE_W(8), .QTY_W(8), .DEPTH(4)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_buy_valid     (buy_valid),
        .o_buy_ready     (buy_ready),
        .i_buy_price     (buy_price),
        .i_buy_qty       (buy_qty),
        .i_sell_valid    (sell_valid),
        .o_sell_ready    (sell_ready),
        .i_sell_price    (sell_price),
        .i_sell_qty      (sell_qty),
        .i_halt          (halt),
        .o_match_signal  (match_signal),
        .o_match_price   (match_price),
        .o_match_qty     (match_qty),
        .o_cancel_signal (cancel_signal),
        .o_buy_count     (buy_count),
        .o_sell_count    (sell_count)
    );

    always #5 clk = ~clk;

    int n_match = 0;
    int n_cancel = 0;
    always @(posedge clk) begin
        if (match_signal)  n_match  <= n_match + 1;
        if (cancel_signal) n_cancel <= n_cancel + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       bv;
        logic [7:0] bp, bq;
        logic       sv;
        logic [7:0] sp, sq;
        logic       m, c;
        logic [7:0] mp, mq;
        logic [2:0] bc, sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic bv, input logic [7:0] bp, input logic [7:0] bq,
                       input logic sv, input logic [7:0] sp, input logic [7:0] sq,
                       input logic m, input logic c, input logic [7:0] mp, input logic [7:0] mq,
                       input logic [2:0] bc, input logic [2:0] sc);
        vec_t v;
        v.rst = rst; v.bv = bv; v.bp = bp; v.bq = bq; v.sv = sv; v.sp = sp; v.sq = sq;
        v.m = m; v.c = c; v.mp = mp; v.mq = mq; v.bc = bc; v.sc = sc;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        buy_valid = 0; buy_price = 0; buy_qty = 0;
        sell_valid = 0; sell_price = 0; sell_qty = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, c0;
        logic found, acc;

        clear_inputs();
        halt = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        tick();
        check("rst_match", match_signal, 0);
        check("rst_cancel", cancel_signal, 0);
        check("rst_price", match_price, 0);
        check("rst_qty", match_qty, 0);
        check("rst_bcount", buy_count, 0);
        check("rst_scount", sell_count, 0);
        check("rst_bready", buy_ready, 1);
        check("rst_sready", sell_ready, 1);

        //  rst bv bp   bq  sv sp  sq   m c mp  mq bc sc
        // buy(100,5) then sell(90,5)
        add(0, 1, 100, 5,  0, 0,  0,   0, 0, 0,  0, 1, 0);
        add(0, 0, 0,   0,  1, 90, 5,   0, 0, 0,  0, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 0,  0, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   1, 0, 90, 5, 0, 0);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 90, 5, 0, 0);
        // buy(50,10), sell(50,3), sell(40,4), then drain head remainder 3
        add(0, 1, 50,  10, 0, 0,  0,   0, 0, 90, 5, 1, 0);
        add(0, 0, 0,   0,  1, 50, 3,   0, 0, 90, 5, 1, 1);
        add(0, 0, 0,   0,  1, 40, 4,   0, 0, 90, 5, 1, 2);
        add(0, 0, 0,   0,  0, 0,  0,   1, 0, 50, 3, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 50, 3, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   1, 0, 40, 4, 1, 0);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 40, 4, 1, 0);
        add(0, 0, 0,   0,  1, 0,  255, 0, 0, 40, 4, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 40, 4, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   1, 0, 0,  3, 0, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 0,  3, 0, 1);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0, 0,  0, 0, 0);
        // buy(10,2), sell(20,2): uncrossed, buy head cancelled
        add(0, 1, 10,  2,  0, 0,  0,   0, 0, 0,  0, 1, 0);
        add(0, 0, 0,   0,  1, 20, 2,   0, 0, 0,  0, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 0,  0, 1, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 1, 0,  0, 0, 1);
        add(0, 0, 0,   0,  0, 0,  0,   0, 0, 0,  0, 0, 1);
        add(1, 0, 0,   0,  0, 0,  0,   0, 0, 0,  0, 0, 0);
        // zero-quantity order is accepted but not stored
        add(0, 1, 70,  0,  0, 0,  0,   0, 0, 0,  0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            buy_valid = vecs[i].bv; buy_price = vecs[i].bp; buy_qty = vecs[i].bq;
            sell_valid = vecs[i].sv; sell_price = vecs[i].sp; sell_qty = vecs[i].sq;
            tick();
            check($sformatf("vec%0d", i),
                  {match_signal, cancel_signal, match_price, match_qty, buy_count, sell_count},
                  {vecs[i].m, vecs[i].c, vecs[i].mp, vecs[i].mq, vecs[i].bc, vecs[i].sc});
        end
        reset = 0;
        clear_inputs();

        // Halt: crossed pair held off for 20 cycles, then released
        halt = 1;
        tick();
        buy_valid = 1; buy_price = 60; buy_qty = 1;
        tick();
        clear_inputs();
        sell_valid = 1; sell_price = 55; sell_qty = 1;
        tick();
        clear_inputs();
        m0 = n_match;
        c0 = n_cancel;
        repeat (20) tick();
        check("halt_no_match", n_match, m0);
        check("halt_no_cancel", n_cancel, c0);
        check("halt_bcount", buy_count, 1);
        check("halt_scount", sell_count, 1);
        halt = 0;
        found = 0;
        for (int k = 0; k < 3 && !found; k++) begin
            tick();
            if (match_signal) begin
                found = 1;
                check("halt_rel_price", match_price, 55);
                check("halt_rel_qty", match_qty, 1);
            end
        end
        check("halt_rel_pulse", found, 1);
        check("halt_rel_counts", {buy_count, sell_count}, 6'd0);

        // Overflow: 4 buys fill the FIFO, 5th is held until a trade pops one
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            buy_valid = 1; buy_price = 8'(100 + i); buy_qty = 1;
            tick();
        end
        check("ovf_bready", buy_ready, 0);
        check("ovf_bcount", buy_count, 4);
        buy_price = 104;
        repeat (3) tick();
        check("ovf_held_bcount", buy_count, 4);
        m0 = n_match;
        sell_valid = 1; sell_price = 0; sell_qty = 255;
        tick();
        sell_valid = 0; sell_price = 0; sell_qty = 0;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (buy_ready) acc = 1;
            tick();
        end
        buy_valid = 0;
        check("ovf_fifth_accepted", acc, 1);
        for (int k = 0; k < 40 && buy_count != 0; k++) tick();
        tick();
        check("ovf_drain_bcount", buy_count, 0);
        check("ovf_trades", n_match - m0, 5);
        check("ovf_scount", sell_count, 1);
        check("ovf_last_trade", {match_price, match_qty}, {8'd0, 8'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/order_matcher.md
Name: order_matcher

Overview:
- Upstream stage of the trade counter.
- Buffers incoming buy and sell orders in two small FIFOs and matches the head orders price-first.
- Emits a one-cycle match_signal pulse per executed trade, plus trade price and quantity. The pulse drives the trade counter's match input.
- Honours the counter's halt_signal: while halted, no further trades are executed.

Parameters:
- PRICE_W, 8, price field width (unsigned).
- QTY_W, 8, quantity field width (unsigned).
- DEPTH, 4, entries per side FIFO (power of 2, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- buy_valid  input  1  buy order present.
- buy_ready  output  1  buy FIFO can accept.
- buy_price  input  PRICE_W  buy limit price.
- buy_qty  input  QTY_W  buy quantity.
- sell_valid  input  1  sell order present.
- sell_ready  output  1  sell FIFO can accept.
- sell_price  input  PRICE_W  sell limit price.
- sell_qty  input  QTY_W  sell quantity.
- halt  input  1  from counter halt_signal; freezes matching.
- match_signal  output  1  one-cycle pulse per trade.
- match_price  output  PRICE_W  trade price, valid with match_signal.
- match_qty  output  QTY_W  trade quantity, valid with match_signal.
- cancel_signal  output  1  one-cycle pulse when the buy head is dropped as uncrossed.
- buy_count  output  clog2(DEPTH)+1  buy FIFO occupancy.
- sell_count  output  clog2(DEPTH)+1  sell FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - FIFOs emptied and FSM to IDLE.
  - match_signal, cancel_signal, match_price, match_qty, buy_count and sell_count all 0.
  - buy_ready and sell_ready are 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all orders and any in-flight trade; no pulse is emitted.
- Input handshake:
  - An order is accepted on a clk edge when valid & ready.
  - ready = !full and does not depend on a same-cycle pop.
  - A push and a pop on the same FIFO in the same cycle are both performed; count is unchanged.
  - Orders with qty==0 are accepted but not stored.
  - Each FIFO entry holds {price, remaining_qty}. The head's remaining_qty is updated in place.
- FSM states: IDLE, CHECK.
  - IDLE: if both FIFOs are non-empty and halt==0, go to CHECK; else stay.
  - CHECK with halt==1: go to IDLE; no trade, no cancel.
  - CHECK, crossed (buy_head.price >= sell_head.price):
    - On this edge, register match_signal=1, match_price=sell_head.price, match_qty=min(buy_rem, sell_rem).
    - Subtract match_qty from both remaining quantities.
    - Pop each head whose remaining quantity reaches 0; both pop when equal.
    - Go to IDLE.
  - CHECK, not crossed: pop the buy head, register cancel_signal=1, go to IDLE.
  - Outputs are registered. Pulses are high for exactly one cycle, then 0.
  - match_price and match_qty hold their last value between pulses.
- Latency and throughput:
  - First match pulse is visible 2 cycles after the cycle in which both FIFOs first become non-empty.
  - Maximum throughput is one trade every 2 cycles.
- Arithmetic:
  - Price comparison is unsigned.
  - min() and subtraction are on QTY_W bits; there is no underflow because match_qty <= both operands.
- Boundaries:
  - Push to a full FIFO is not accepted; the sender must hold the order.
  - FIFO pointers wrap modulo DEPTH.
  - If halt rises while in CHECK, no trade is executed.
  - Pushes are still accepted while halt is high.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0; buy_ready=sell_ready=1; counts 0.
- Buy(100,5) then sell(90,5) -> exactly one match_signal pulse with match_price=90, match_qty=5; both counts return to 0; cancel_signal never asserted.
- Buy(50,10), sell(50,3), sell(40,4) -> two pulses: (50,3) then (40,4); final buy_count=1 with head remaining_qty=3; sell_count=0.
- Buy(10,2), sell(20,2) -> one cancel_signal pulse and no match_signal; buy_count=0, sell_count=1.
- Halt scenario:
  - Set halt=1, then push crossed pair buy(60,1), sell(55,1) -> no pulses for 20 cycles; counts stay 1/1.
  - Set halt=0 -> match_signal pulse with (55,1) within 3 cycles.
- DEPTH=4 overflow: 5 buys pushed with no sells -> buy_ready=0 after the 4th accept; the 5th is held; buy_count=4.
  - Then push sell(0,255) -> trades drain the buys; the 5th buy is accepted once buy_ready returns to 1.
